// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register carrying a control payload and an exception sideband (flag, code, PC).
// Optional feature: define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_hs #(
    parameter int unsigned      WIDTH   = 11,
    parameter int unsigned      PC_W    = 32,
    parameter int unsigned      CNT_W   = 16,
    parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_exc,
    input  logic [4:0]       in_exccode,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_exc,
    output logic [4:0]       out_exccode,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // Payload and sideband are one packed entry so they can never be loaded separately.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             exc;
        logic [4:0]       exccode;
        logic [PC_W-1:0]  pc;
    } entry_t;

    localparam entry_t          CLR_ENTRY = '{data: CLR_VAL, exc: 1'b0, exccode: 5'd0, pc: {PC_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_nxt_s;
    entry_t           main_r;
    entry_t           main_nxt_s;
    entry_t           in_entry_s;
    logic             out_valid_r;
    logic             out_valid_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] stall_cnt_nxt_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             in_ready_s;

    assign in_entry_s = '{data: in_data, exc: in_exc, exccode: in_exccode, pc: in_pc};
    assign in_xfer_s  = in_valid & in_ready_s;
    assign out_xfer_s = out_valid_r & out_ready;

`ifdef PIPE_SKID_EN
    entry_t skid_r;
    entry_t skid_nxt_s;
    logic   in_ready_r;
    logic   in_ready_nxt_s;

    assign in_ready_s = in_ready_r;

    // Next-state, next-entry and next-ready for the two-entry skid buffer; flush overrides every transfer.
    always_comb begin
        state_nxt_s    = state_r;
        main_nxt_s     = main_r;
        skid_nxt_s     = skid_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = CLR_ENTRY;
            skid_nxt_s  = CLR_ENTRY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = in_entry_s;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = in_entry_s;
                    end else if (in_xfer_s) begin
                        state_nxt_s = ST_SKID;
                        skid_nxt_s  = in_entry_s;
                    end else if (out_xfer_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the drain of the older entry can happen.
                    if (out_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = skid_r;
                        skid_nxt_s  = CLR_ENTRY;
                    end else begin
                        state_nxt_s = ST_SKID;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = CLR_ENTRY;
                    skid_nxt_s  = CLR_ENTRY;
                end
            endcase
        end
        in_ready_nxt_s = (state_nxt_s != ST_SKID);
    end

    // Skid holding register and registered upstream ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_r     <= CLR_ENTRY;
            in_ready_r <= 1'b1;
        end else begin
            skid_r     <= skid_nxt_s;
            in_ready_r <= in_ready_nxt_s;
        end
    end
`else
    assign in_ready_s = ~out_valid_r | out_ready;

    // Next-state and next-entry for the single-register stage; flush overrides every transfer.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = CLR_ENTRY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = in_entry_s;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = in_entry_s;
                    end else if (out_xfer_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = CLR_ENTRY;
                end
            endcase
        end
    end
`endif

    // out_valid is kept as its own flop so the output never decodes the state encoding.
    always_comb begin
        out_valid_nxt_s = out_valid_r;
        if (state_nxt_s != ST_EMPTY) begin
            out_valid_nxt_s = 1'b1;
        end else begin
            out_valid_nxt_s = 1'b0;
        end
    end

    // Saturating count of cycles spent presenting an entry that downstream refuses; flush does not clear it.
    always_comb begin
        stall_cnt_nxt_s = stall_cnt_r;
        if (out_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_nxt_s = stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // State, output entry and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            main_r      <= CLR_ENTRY;
            out_valid_r <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_data    = main_r.data;
    assign out_exc     = main_r.exc;
    assign out_exccode = main_r.exccode;
    assign out_pc      = main_r.pc;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: queue-based reference model checked every cycle, plus literal expectations.
module tb_pipe_stage_hs;

    localparam int unsigned      WIDTH   = 11;
    localparam int unsigned      PC_W    = 32;
    localparam int unsigned      CNT_W   = 4;
    localparam logic [WIDTH-1:0] CLR     = 11'h013;
    localparam int               CNT_MAX = 15;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_exc;
    logic [4:0]       in_exccode;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_exc;
    logic [4:0]       out_exccode;
    logic [PC_W-1:0]  out_pc;
    logic [CNT_W-1:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pipe_stage_hs #(.WIDTH(WIDTH), .PC_W(PC_W), .CNT_W(CNT_W), .CLR_VAL(CLR)) dut (
        .clk(clk), .reset(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_exc(in_exc), .in_exccode(in_exccode), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc(out_exc), .out_exccode(out_exccode), .out_pc(out_pc),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a FIFO of entries with capacity 1 (plain) or 2 (skid).
    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             e;
        logic [4:0]       c;
        logic [PC_W-1:0]  pc;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    bit   m_clr;

    function automatic bit m_in_ready();
`ifdef PIPE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || (out_ready == 1'b1);
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt = 0;
        m_clr = 1'b1;
    endtask

    task automatic model_step();
        bit ix;
        bit ox;
        ix = (in_valid == 1'b1) && m_in_ready();
        ox = (q.size() > 0) && (out_ready == 1'b1);
        if ((q.size() > 0) && (out_ready == 1'b0) && (m_cnt < CNT_MAX)) m_cnt++;
        if (flush == 1'b1) begin
            q.delete();
            m_clr = 1'b1;
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) begin
                q.push_back({in_data, in_exc, in_exccode, in_pc});
                m_clr = 1'b0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_in_ready()});
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
        if (q.size() > 0) begin
            chk("out_data", {53'd0, out_data}, {53'd0, q[0].d});
            chk("out_exc", {63'd0, out_exc}, {63'd0, q[0].e});
            chk("out_exccode", {59'd0, out_exccode}, {59'd0, q[0].c});
            chk("out_pc", {32'd0, out_pc}, {32'd0, q[0].pc});
        end else if (m_clr) begin
            chk("clr_data", {53'd0, out_data}, {53'd0, CLR});
            chk("clr_exc", {63'd0, out_exc}, 64'd0);
            chk("clr_exccode", {59'd0, out_exccode}, 64'd0);
            chk("clr_pc", {32'd0, out_pc}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 11'h000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [15:0] pat_iv;
    logic [15:0] pat_or;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 11'h000; in_exc = 1'b0; in_exccode = 5'd0; in_pc = 32'h0;

        // 1. reset held three cycles
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {53'd0, out_data}, {53'd0, CLR});
        chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // 2. streaming
        drive(1'b1, 11'h001, 1'b1); tick();
        chk("stream_0", {52'd0, out_valid, out_data}, {52'd0, 1'b1, 11'h001});
        drive(1'b1, 11'h002, 1'b1); tick();
        chk("stream_1", {52'd0, out_valid, out_data}, {52'd0, 1'b1, 11'h002});
        drive(1'b1, 11'h003, 1'b1); tick();
        chk("stream_2", {52'd0, out_valid, out_data}, {52'd0, 1'b1, 11'h003});
        drive(1'b0, 11'h000, 1'b1); tick();
        chk("stream_end", {63'd0, out_valid}, 64'd0);

        // 3. backpressure
        do_reset();
        drive(1'b1, 11'h055, 1'b1); tick();
        drive(1'b1, 11'h0AA, 1'b0);
        repeat (4) tick();
        chk("bp_hold", {53'd0, out_data}, {53'd0, 11'h055});
        chk("bp_cnt", {60'd0, stall_cnt}, 64'd4);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b0, 11'h000, 1'b1); tick();
`ifdef PIPE_SKID_EN
        chk("bp_skid_next", {52'd0, out_valid, out_data}, {52'd0, 1'b1, 11'h0AA});
`else
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
`endif
        tick();

        // 4. flush while full (skid build: two entries held)
        do_reset();
        drive(1'b1, 11'h011, 1'b0); tick();
        drive(1'b1, 11'h022, 1'b0); tick();
        drive(1'b1, 11'h033, 1'b0); flush = 1'b1; tick();
        flush = 1'b0; drive(1'b0, 11'h000, 1'b1);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_data", {53'd0, out_data}, {53'd0, CLR});
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("fl_dropped", {63'd0, out_valid}, 64'd0);

        // 5. exception sideband
        drive(1'b1, 11'h007, 1'b1); in_exc = 1'b1; in_exccode = 5'd12; in_pc = 32'h0000_3008; tick();
        chk("exc_flag", {63'd0, out_exc}, 64'd1);
        chk("exc_code", {59'd0, out_exccode}, 64'd12);
        chk("exc_pc", {32'd0, out_pc}, 64'h3008);
        drive(1'b1, 11'h008, 1'b1); in_exc = 1'b0; in_exccode = 5'd0; in_pc = 32'h0000_300C; tick();
        chk("exc_clear", {63'd0, out_exc}, 64'd0);
        drive(1'b0, 11'h000, 1'b1); tick();

        // mixed traffic with a flush in the middle, checked by the model
        pat_iv = 16'b1011_1110_0111_1101;
        pat_or = 16'b0110_0101_1100_1011;
        for (int i = 0; i < 16; i++) begin
            drive(pat_iv[i], 11'(11'h100 + i), pat_or[i]);
            in_exc = pat_iv[i] & pat_or[i];
            in_exccode = 5'(i);
            in_pc = 32'h0000_4000 + 32'(4 * i);
            flush = (i == 10) ? 1'b1 : 1'b0;
            tick();
        end
        flush = 1'b0; in_exc = 1'b0;
        drive(1'b0, 11'h000, 1'b1); tick(); tick();

        // 6. saturation
        do_reset();
        drive(1'b1, 11'h066, 1'b0); tick();
        drive(1'b0, 11'h000, 1'b0);
        repeat (19) tick();
        chk("sat_15", {60'd0, stall_cnt}, 64'd15);
        tick();
        chk("sat_hold", {60'd0, stall_cnt}, 64'd15);

        // 7. asynchronous reset between edges while holding entries
        do_reset();
        drive(1'b1, 11'h0C3, 1'b0); tick();
        drive(1'b1, 11'h03C, 1'b0); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_data", {53'd0, out_data}, {53'd0, CLR});
        chk("ar_cnt", {60'd0, stall_cnt}, 64'd0);
        chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b0, 11'h000, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
